// File: rtl/inst_fetch_if.sv
// Bundle of the fetch unit's signals: pc stage in, instruction memory,
// decode out and the redirect flush. master = fetch unit, slave = surroundings.
interface inst_fetch_if #(
    parameter int INST_WIDTH      = 32,
    parameter int INST_ADDR_WIDTH = 32
);
    logic [INST_ADDR_WIDTH-1:0] pc_i;
    logic                       pc_valid_i;
    logic                       pc_ready_o;
    logic                       imem_req_o;
    logic [INST_ADDR_WIDTH-1:0] imem_addr_o;
    logic                       imem_gnt_i;
    logic                       imem_rvalid_i;
    logic [INST_WIDTH-1:0]      imem_rdata_i;
    logic                       imem_err_i;
    logic [INST_WIDTH-1:0]      inst_o;
    logic [INST_ADDR_WIDTH-1:0] pc_o;
    logic                       inst_valid_o;
    logic                       inst_ready_i;
    logic                       flush_i;
    logic [1:0]                 fetch_err_o;

    modport master (
        input  pc_i, pc_valid_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
               imem_err_i, inst_ready_i, flush_i,
        output pc_ready_o, imem_req_o, imem_addr_o, inst_o, pc_o,
               inst_valid_o, fetch_err_o
    );

    modport slave (
        output pc_i, pc_valid_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i,
               imem_err_i, inst_ready_i, flush_i,
        input  pc_ready_o, imem_req_o, imem_addr_o, inst_o, pc_o,
               inst_valid_o, fetch_err_o
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding memory request, timeout on a missing
// response, flush/redirect with draining of an already granted request.
module inst_fetch #(
    parameter int INST_WIDTH      = 32,
    parameter int INST_ADDR_WIDTH = 32,
    parameter int TIMEOUT         = 255
) (
    input  logic         clk,
    input  logic         rst,
    inst_fetch_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HOLD} state_t;

    // Handshake outputs kept as flops, loaded together with the state:
    // {pc_ready, imem_req, inst_valid}. Reset value 0 keeps all three low
    // while rst is asserted; pc_ready rises on the first edge after release.
    localparam logic [2:0] O_IDLE = 3'b100;
    localparam logic [2:0] O_REQ  = 3'b010;
    localparam logic [2:0] O_HOLD = 3'b001;
    localparam logic [2:0] O_NONE = 3'b000;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t                     state;
    logic [2:0]                 outs_q;
    logic [7:0]                 cnt_q;
    logic [INST_ADDR_WIDTH-1:0] pc_q;
    logic [INST_ADDR_WIDTH-1:0] pc_o_q;
    logic [INST_WIDTH-1:0]      inst_q;
    logic [1:0]                 err_q;

    // Fetch FSM; flush always wins over the other inputs of the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            outs_q <= O_NONE;
            cnt_q  <= '0;
            pc_q   <= '0;
            pc_o_q <= '0;
            inst_q <= '0;
            err_q  <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    outs_q <= O_IDLE;
                    if (!bus.flush_i && bus.pc_valid_i) begin
                        pc_q <= bus.pc_i;
                        if (bus.pc_i[1:0] != 2'b00) begin
                            // misaligned: report without touching memory
                            pc_o_q <= bus.pc_i;
                            inst_q <= '0;
                            err_q  <= 2'b01;
                            state  <= HOLD;
                            outs_q <= O_HOLD;
                        end else begin
                            state  <= REQ;
                            outs_q <= O_REQ;
                        end
                    end
                end
                REQ: begin
                    if (bus.flush_i) begin
                        // a grant seen with the flush still owes us a response
                        state  <= bus.imem_gnt_i ? DRAIN : IDLE;
                        outs_q <= bus.imem_gnt_i ? O_NONE : O_IDLE;
                    end else if (bus.imem_gnt_i) begin
                        cnt_q  <= '0;
                        state  <= WAIT;
                        outs_q <= O_NONE;
                    end
                end
                WAIT: begin
                    if (bus.flush_i) begin
                        state  <= bus.imem_rvalid_i ? IDLE : DRAIN;
                        outs_q <= bus.imem_rvalid_i ? O_IDLE : O_NONE;
                    end else if (bus.imem_rvalid_i) begin
                        inst_q <= bus.imem_rdata_i;
                        err_q  <= bus.imem_err_i ? 2'b10 : 2'b00;
                        pc_o_q <= pc_q;
                        state  <= HOLD;
                        outs_q <= O_HOLD;
                    end else if (cnt_q == TO_LAST) begin
                        inst_q <= '0;
                        err_q  <= 2'b11;
                        pc_o_q <= pc_q;
                        state  <= HOLD;
                        outs_q <= O_HOLD;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DRAIN: begin
                    if (bus.imem_rvalid_i) begin
                        state  <= IDLE;
                        outs_q <= O_IDLE;
                    end
                end
                HOLD: begin
                    if (bus.flush_i || bus.inst_ready_i) begin
                        state  <= IDLE;
                        outs_q <= O_IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    outs_q <= O_IDLE;
                end
            endcase
        end
    end

    assign bus.pc_ready_o   = outs_q[2];
    assign bus.imem_req_o   = outs_q[1];
    assign bus.inst_valid_o = outs_q[0];
    assign bus.imem_addr_o  = pc_q;
    assign bus.inst_o       = inst_q;
    assign bus.pc_o         = pc_o_q;
    assign bus.fetch_err_o  = err_q;
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: scoreboard of expected fetch results, a memory
// model driven by per-request plans, and directed flush/reset sequences.
module tb_inst_fetch;
    localparam int IW = 32;
    localparam int AW = 32;
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_if #(.INST_WIDTH(IW), .INST_ADDR_WIDTH(AW)) bus ();

    inst_fetch #(.INST_WIDTH(IW), .INST_ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  err;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        int          gd;    // cycles the request waits for grant
        int          rd;    // WAIT cycle on which the response arrives
        logic [31:0] data;
        logic        err;
    } plan_t;

    exp_t  exp_q[$];
    plan_t mem_q[$];
    int    n_chk  = 0;
    int    n_fail = 0;
    int    ready_mode = 0;  // 0: always ready, 1: random, 2: held low

    // memory inputs: automatic model or manual driving from directed tests
    logic        mem_auto = 1'b1;
    logic        a_gnt = 1'b0, a_rv = 1'b0, a_err = 1'b0;
    logic [31:0] a_data = '0;
    logic        m_gnt = 1'b0, m_rv = 1'b0, m_err = 1'b0;
    logic [31:0] m_data = '0;
    assign bus.imem_gnt_i    = mem_auto ? a_gnt  : m_gnt;
    assign bus.imem_rvalid_i = mem_auto ? a_rv   : m_rv;
    assign bus.imem_err_i    = mem_auto ? a_err  : m_err;
    assign bus.imem_rdata_i  = mem_auto ? a_data : m_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // memory model: grants after plan.gd cycles, answers on WAIT cycle plan.rd
    // (beyond TO the answer lands after the timeout and must be ignored)
    int    m_phase = 0;
    int    m_cnt   = 0;
    plan_t cur;
    always @(negedge clk) begin
        a_gnt  = 1'b0;
        a_rv   = 1'b0;
        a_err  = 1'b0;
        a_data = $urandom;
        if (!rst) begin
            m_phase = 0;
            m_cnt   = 0;
        end else if (m_phase == 0) begin
            if (mem_auto && bus.imem_req_o) begin
                if (m_cnt == 0 && mem_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_req: addr %0h with no fetch pending", bus.imem_addr_o);
                end else begin
                    if (m_cnt == 0) cur = mem_q.pop_front();
                    chk("imem_addr", bus.imem_addr_o, cur.pc);
                    if (m_cnt == cur.gd) begin
                        a_gnt   = 1'b1;
                        m_phase = 1;
                        m_cnt   = 0;
                    end else begin
                        m_cnt++;
                    end
                end
            end
        end else begin
            m_cnt++;
            if (m_cnt == cur.rd) begin
                a_rv    = 1'b1;
                a_data  = cur.data;
                a_err   = cur.err;
                m_phase = 0;
                m_cnt   = 0;
            end
        end
    end

    // monitor: drives inst_ready and checks every consumed instruction
    always @(negedge clk) begin : mon
        logic r;
        exp_t e;
        case (ready_mode)
            0:       r = 1'b1;
            1:       r = 1'($urandom_range(0, 1));
            default: r = 1'b0;
        endcase
        bus.inst_ready_i = r;
        if (rst && bus.inst_valid_o && r) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_inst: inst %0h pc %0h presented, none expected",
                         bus.inst_o, bus.pc_o);
            end else begin
                e = exp_q.pop_front();
                chk("inst_o", bus.inst_o, e.inst);
                chk("pc_o", bus.pc_o, e.pc);
                chk("fetch_err", 32'(bus.fetch_err_o), 32'(e.err));
            end
        end
    end

    // offer a pc and record what the specification says must come back
    task automatic issue(input logic [31:0] pc, input int gd, input int rd,
                         input logic [31:0] data, input logic e);
        int    t;
        exp_t  x;
        plan_t p;
        t = 0;
        bus.pc_i       = pc;
        bus.pc_valid_i = 1'b1;
        while (!bus.pc_ready_o && t <= 200) begin
            @(negedge clk);
            t++;
        end
        if (t > 200) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout: pc %0h never accepted", pc);
        end else begin
            x.pc = pc;
            if (pc[1:0] != 2'b00) begin
                x.inst = '0;
                x.err  = 2'b01;
            end else begin
                p.pc = pc; p.gd = gd; p.rd = rd; p.data = data; p.err = e;
                mem_q.push_back(p);
                x.inst = (rd <= TO) ? data : 32'h0;
                x.err  = (rd > TO) ? 2'b11 : (e ? 2'b10 : 2'b00);
            end
            exp_q.push_back(x);
        end
        @(negedge clk);
        bus.pc_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !bus.pc_ready_o) && t <= 300) begin
            @(negedge clk);
            t++;
        end
        if (t > 300) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results still expected", exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // manual acceptance used with the hand-driven memory
    task automatic accept(input logic [31:0] pc);
        bus.pc_i       = pc;
        bus.pc_valid_i = 1'b1;
        chk("accept_ready", 32'(bus.pc_ready_o), 32'd1);
        @(negedge clk);
        bus.pc_valid_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] pc;
        bus.pc_i       = '0;
        bus.pc_valid_i = 1'b0;
        bus.flush_i    = 1'b0;

        // reset state
        #12;
        chk("rst_pc_ready", 32'(bus.pc_ready_o), 32'd0);
        chk("rst_req", 32'(bus.imem_req_o), 32'd0);
        chk("rst_valid", 32'(bus.inst_valid_o), 32'd0);
        chk("rst_inst", bus.inst_o, 32'd0);
        chk("rst_pc_o", bus.pc_o, 32'd0);
        chk("rst_err", 32'(bus.fetch_err_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(bus.pc_ready_o), 32'd1);

        // nominal fetch and its latency
        issue(32'h8000_0000, 0, 1, 32'h0010_0093, 1'b0);
        chk("lat_req", 32'(bus.imem_req_o), 32'd1);
        chk("lat_addr", bus.imem_addr_o, 32'h8000_0000);
        chk("lat_n1", 32'(bus.inst_valid_o), 32'd0);
        @(negedge clk);
        chk("lat_n2", 32'(bus.inst_valid_o), 32'd0);
        @(negedge clk);
        chk("lat_n3", 32'(bus.inst_valid_o), 32'd1);
        chk("lat_inst", bus.inst_o, 32'h0010_0093);
        wait_idle();

        // misaligned pc, decode stalls for 5 cycles
        ready_mode = 2;
        issue(32'h8000_0002, 0, 1, 32'h0, 1'b0);
        repeat (5) begin
            chk("mis_valid", 32'(bus.inst_valid_o), 32'd1);
            chk("mis_req", 32'(bus.imem_req_o), 32'd0);
            chk("mis_ready", 32'(bus.pc_ready_o), 32'd0);
            chk("mis_inst", bus.inst_o, 32'd0);
            chk("mis_pc", bus.pc_o, 32'h8000_0002);
            chk("mis_err", 32'(bus.fetch_err_o), 32'd1);
            @(negedge clk);
        end
        ready_mode = 0;
        wait_idle();

        // bus error, then timeout with late responses, then a clean fetch
        issue(32'h0000_1000, 1, 2, 32'hDEAD_BEEF, 1'b1);
        wait_idle();
        issue(32'h0000_1004, 0, 5, 32'h1234_5678, 1'b0);
        repeat (4) @(negedge clk);
        chk("to_wait4", 32'(bus.inst_valid_o), 32'd0);
        @(negedge clk);
        chk("to_hold", 32'(bus.inst_valid_o), 32'd1);
        chk("to_err", 32'(bus.fetch_err_o), 32'd3);
        wait_idle();
        issue(32'h0000_1008, 0, 6, 32'h5555_AAAA, 1'b0);
        issue(32'h0000_100C, 2, 3, 32'hCAFE_F00D, 1'b0);
        wait_idle();

        // randomized traffic with random decode back-pressure
        ready_mode = 1;
        for (int i = 0; i < 40; i++) begin
            pc = $urandom;
            if ($urandom_range(0, 5) != 0) pc[1:0] = 2'b00;
            else if (pc[1:0] == 2'b00) pc[0] = 1'b1;
            issue(pc, int'($urandom_range(0, 3)), int'($urandom_range(1, 6)),
                  $urandom, ($urandom_range(0, 3) == 0));
        end
        ready_mode = 0;
        wait_idle();

        // flush scenarios with a hand-driven memory
        mem_auto = 1'b0;
        accept(32'h0000_2000);
        chk("fw_req", 32'(bus.imem_req_o), 32'd1);
        m_gnt = 1'b1;
        @(negedge clk);
        m_gnt = 1'b0;
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("fw_drain_ready", 32'(bus.pc_ready_o), 32'd0);
        chk("fw_drain_valid", 32'(bus.inst_valid_o), 32'd0);
        @(negedge clk);
        m_rv = 1'b1; m_data = $urandom;
        chk("fw_rv_ready", 32'(bus.pc_ready_o), 32'd0);
        @(negedge clk);
        m_rv = 1'b0;
        chk("fw_after_ready", 32'(bus.pc_ready_o), 32'd1);
        chk("fw_after_valid", 32'(bus.inst_valid_o), 32'd0);

        accept(32'h0000_2004);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("fr_req_drop", 32'(bus.imem_req_o), 32'd0);
        chk("fr_ready", 32'(bus.pc_ready_o), 32'd1);

        accept(32'h0000_2008);
        bus.flush_i = 1'b1; m_gnt = 1'b1;
        @(negedge clk);
        m_gnt = 1'b0;
        chk("frg_req_drop", 32'(bus.imem_req_o), 32'd0);
        chk("frg_drain", 32'(bus.pc_ready_o), 32'd0);
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("frg_flush_ign", 32'(bus.pc_ready_o), 32'd0);
        m_rv = 1'b1;
        @(negedge clk);
        m_rv = 1'b0;
        chk("frg_idle", 32'(bus.pc_ready_o), 32'd1);

        accept(32'h0000_200C);
        m_gnt = 1'b1;
        @(negedge clk);
        m_gnt = 1'b0;
        bus.flush_i = 1'b1; m_rv = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0; m_rv = 1'b0;
        chk("fwr_ready", 32'(bus.pc_ready_o), 32'd1);
        chk("fwr_valid", 32'(bus.inst_valid_o), 32'd0);

        ready_mode = 2;
        accept(32'h0000_2011);
        chk("fh_valid", 32'(bus.inst_valid_o), 32'd1);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        chk("fh_drop", 32'(bus.inst_valid_o), 32'd0);
        chk("fh_ready", 32'(bus.pc_ready_o), 32'd1);
        ready_mode = 0;

        bus.pc_i = 32'h0000_3000; bus.pc_valid_i = 1'b1; bus.flush_i = 1'b1;
        @(negedge clk);
        bus.pc_valid_i = 1'b0; bus.flush_i = 1'b0;
        chk("fi_blocked", 32'(bus.pc_ready_o), 32'd1);
        chk("fi_noreq", 32'(bus.imem_req_o), 32'd0);

        // asynchronous reset in the middle of WAIT
        accept(32'h0000_4000);
        m_gnt = 1'b1;
        @(negedge clk);
        m_gnt = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("ar_ready", 32'(bus.pc_ready_o), 32'd0);
        chk("ar_req", 32'(bus.imem_req_o), 32'd0);
        chk("ar_valid", 32'(bus.inst_valid_o), 32'd0);
        chk("ar_addr", bus.imem_addr_o, 32'd0);
        chk("ar_pc_o", bus.pc_o, 32'd0);
        chk("ar_err", 32'(bus.fetch_err_o), 32'd0);
        @(negedge clk);
        exp_q.delete();
        mem_q.delete();
        rst = 1'b1;
        mem_auto = 1'b1;
        @(negedge clk);
        issue(32'h0000_5000, 1, 1, 32'h0BAD_C0DE, 1'b0);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter INST_WIDTH, default 32, instruction word width.
REQ-002 Parameter INST_ADDR_WIDTH, default 32, fetch address width.
REQ-003 Parameter TIMEOUT, default 255, maximum WAIT cycles before timeout; range 1..255.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 pc_i  input  INST_ADDR_WIDTH  fetch address from the pc stage.
REQ-007 pc_valid_i  input  1  pc_i valid.
REQ-008 pc_ready_o  output  1  fetch unit accepts pc_i.
REQ-009 imem_req_o  output  1  instruction memory request.
REQ-010 imem_addr_o  output  INST_ADDR_WIDTH  request address.
REQ-011 imem_gnt_i  input  1  memory accepted the request.
REQ-012 imem_rvalid_i  input  1  response valid; never asserted in the grant cycle.
REQ-013 imem_rdata_i  input  INST_WIDTH  response instruction word.
REQ-014 imem_err_i  input  1  response bus error; qualified by imem_rvalid_i.
REQ-015 inst_o  output  INST_WIDTH  fetched instruction to inst_decode.
REQ-016 pc_o  output  INST_ADDR_WIDTH  address of inst_o.
REQ-017 inst_valid_o  output  1  inst_o/pc_o/fetch_err_o valid.
REQ-018 inst_ready_i  input  1  decode consumes inst_o.
REQ-019 flush_i  input  1  abandon the current fetch (redirect).
REQ-020 fetch_err_o  output  2  00 ok, 01 misaligned, 10 bus error, 11 timeout.

Function
REQ-021 FSM states SHALL be IDLE, REQ, WAIT, DRAIN and HOLD; at most one memory request outstanding.
REQ-022 IDLE: pc_ready_o=1; on pc_valid_i, latch pc_i into pc_q; pc_i[1:0]!=0 -> HOLD with err 01 and inst 0, no memory access; else -> REQ.
REQ-023 REQ: imem_req_o=1, imem_addr_o=pc_q held stable; on imem_gnt_i -> WAIT, timeout counter cleared to 0.
REQ-024 WAIT: imem_req_o=0; on imem_rvalid_i capture imem_rdata_i into inst_o, err = imem_err_i ? 10 : 00, -> HOLD.
REQ-025 WAIT without rvalid: counter increments; when counter reaches TIMEOUT-1 and no rvalid, -> HOLD with err 11, inst_o=0.
REQ-026 HOLD: inst_valid_o=1, inst_o/pc_o/fetch_err_o stable; on inst_ready_i -> IDLE.
REQ-027 Nominal latency: pc accepted cycle N, gnt in N+1, rvalid in N+2, inst_valid_o high from N+3.
REQ-028 flush_i in REQ -> IDLE, request withdrawn the next cycle even if gnt is seen the same cycle; a same-cycle gnt -> DRAIN instead.
REQ-029 flush_i in WAIT with rvalid the same cycle -> IDLE, response discarded; without rvalid -> DRAIN.
REQ-030 DRAIN: pc_ready_o=0, inst_valid_o=0; on imem_rvalid_i discard the response and -> IDLE; flush_i ignored.
REQ-031 flush_i in HOLD -> IDLE, inst_valid_o deasserted next cycle; flush_i in IDLE blocks acceptance that cycle.
REQ-032 flush_i has priority over inst_ready_i and pc_valid_i in the same cycle.
REQ-033 imem_rvalid_i in IDLE, REQ or HOLD (late response after timeout) SHALL be ignored.
REQ-034 pc_ready_o, imem_req_o and inst_valid_o SHALL be decoded from state only, with no combinational path from any input.

Reset
REQ-035 rst low SHALL force IDLE immediately, independent of clk.
REQ-036 rst low SHALL clear pc_q, inst_o, pc_o, fetch_err_o and the counter to 0.
REQ-037 imem_req_o, inst_valid_o and pc_ready_o SHALL be 0 while rst is low; pc_ready_o=1 from the first cycle after release.
REQ-038 Reset during WAIT SHALL drop the outstanding request; the bench SHALL reset the memory model alongside.

Verification
REQ-039 pc_i=0x80000000 valid, gnt same cycle, rvalid next cycle with rdata=0x00100093 -> inst_valid_o 3 cycles after acceptance, inst_o=0x00100093, pc_o=0x80000000, err 00.
REQ-040 pc_i=0x80000002 -> no imem_req_o, HOLD with err 01, inst_o=0, inst_valid_o held until inst_ready_i.
REQ-041 rvalid with imem_err_i=1 -> err 10; no rvalid for TIMEOUT=4 cycles -> err 11 after 4 WAIT cycles; a later rvalid is ignored.
REQ-042 flush_i in WAIT, rvalid 2 cycles later -> DRAIN, response not presented, pc_ready_o=1 the cycle after rvalid.
REQ-043 inst_ready_i low for 5 cycles in HOLD -> inst_o/pc_o stable, pc_ready_o=0 throughout; rst low mid-WAIT -> all outputs 0 asynchronously.
